// File: rtl/aemb2_xwb_pkg.sv
// Shared types and constants for the aeMB2 iwb/dwb -> xwb arbiter.
package aemb2_xwb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam int TGA_SRC = 1;
    localparam int TGA_THR = 0;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

endpackage

// File: rtl/aemb2_xwb_wdt.sv
// Ack watchdog: expires on the TMO-th consecutive stalled cycle; TMO=0 builds nothing.
module aemb2_xwb_wdt #(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);

    generate
        if (TMO > 0) begin : g_wdt
            localparam int W = $clog2(TMO + 1);
            logic [W-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst || clr)
                    cnt <= '0;
                else if (run)
                    cnt <= cnt + 1'b1;
            end

            // Fires combinationally so the forced ack lands on the TMO-th stall;
            // a real ack that cycle drops run and wins.
            assign expire = run && (cnt == W'(TMO - 1));
        end else begin : g_nowdt
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/aemb2_xwb_arb.sv
// Shares one xwb slave port between aeMB2 iwb and dwb: data priority,
// instruction starvation guard, per-transfer ack watchdog.
module aemb2_xwb_arb
    import aemb2_xwb_pkg::*;
#(
    parameter int AW  = 16,
    parameter int ISL = 4,
    parameter int TMO = 255
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,

    input  logic          iwb_stb_i,
    input  logic [AW-1:2] iwb_adr_i,
    input  logic          iwb_tga_i,
    output logic          iwb_ack_o,
    output logic [31:0]   iwb_dat_o,

    input  logic          dwb_cyc_i,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:2] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    input  logic          dwb_tga_i,
    output logic          dwb_ack_o,
    output logic [31:0]   dwb_dat_o,

    output logic          xwb_cyc_o,
    output logic          xwb_stb_o,
    output logic          xwb_wre_o,
    output logic [3:0]    xwb_sel_o,
    output logic [AW-1:2] xwb_adr_o,
    output logic [31:0]   xwb_dat_o,
    output logic [1:0]    xwb_tga_o,
    input  logic          xwb_ack_i,
    input  logic [31:0]   xwb_dat_i,

    output logic          tmo_o
);

    localparam logic [3:0] ISL_C = 4'(ISL);

    state_t     state;
    logic [3:0] scnt;
    logic       ign, dgn, gnt, expire;

    assign ign = (state == IGNT);
    assign dgn = (state == DGNT);
    assign gnt = ign | dgn;

    aemb2_xwb_wdt #(.TMO(TMO)) u_wdt (
        .clk    (sys_clk_i),
        .rst    (sys_rst_i),
        .run    (xwb_stb_o & ~xwb_ack_i),
        .clr    (~gnt | xwb_ack_i),
        .expire (expire)
    );

    always_comb begin
        xwb_cyc_o = gnt;
        xwb_stb_o = 1'b0;
        xwb_wre_o = dwb_wre_i;
        xwb_sel_o = dwb_sel_i;
        xwb_adr_o = dwb_adr_i;
        xwb_dat_o = dwb_dat_i;
        xwb_tga_o = '0;
        xwb_tga_o[TGA_SRC] = SRC_D;
        xwb_tga_o[TGA_THR] = dwb_tga_i;
        if (ign) begin
            xwb_stb_o = iwb_stb_i;
            xwb_wre_o = 1'b0;
            xwb_sel_o = 4'hF;
            xwb_adr_o = iwb_adr_i;
            xwb_tga_o[TGA_SRC] = SRC_I;
            xwb_tga_o[TGA_THR] = iwb_tga_i;
        end else if (dgn) begin
            xwb_stb_o = dwb_stb_i;
        end
    end

    assign iwb_ack_o = ign & (xwb_ack_i | expire);
    assign dwb_ack_o = dgn & (xwb_ack_i | expire);
    assign iwb_dat_o = (ign & expire) ? 32'h0 : xwb_dat_i;
    assign dwb_dat_o = (dgn & expire) ? 32'h0 : xwb_dat_i;
    assign tmo_o     = expire;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state <= IDLE;
            scnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // iwb only wins a contended slot once it has lost ISL in a row
                    if (dwb_stb_i && !(iwb_stb_i && scnt == ISL_C)) begin
                        state <= DGNT;
                        if (iwb_stb_i)
                            scnt <= scnt + 1'b1;
                    end else if (iwb_stb_i) begin
                        state <= IGNT;
                        scnt  <= '0;
                    end
                end
                IGNT: begin
                    if (xwb_ack_i || expire || !iwb_stb_i)
                        state <= IDLE;
                end
                DGNT: begin
                    if (expire)
                        state <= IDLE;
                    else if (xwb_ack_i) begin
                        if (!dwb_cyc_i)
                            state <= IDLE;
                    end else if (!dwb_cyc_i && !dwb_stb_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
